// File: rtl/pulse_catcher_pkg.sv
// Shared definitions for the pulse catcher: edge-select encodings and the
// helpers used to size the per-channel counters.
package pulse_catcher_pkg;

    // Per-channel edge select, two bits per channel on the mode bus.
    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Larger of two integers, used to size the shared repeat counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold the values 0..n, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pulse_catcher_channel.sv
// One input channel: synchronizer chain, debounce filter, edge detector and
// optional auto-repeat. Reset release is expected to be synchronous to clk.
module pulse_catcher_channel
    import pulse_catcher_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
    input  logic [1:0] mode,
    output logic       out,
    output logic       level
);

    localparam int DC_W = cnt_width(DEBOUNCE_CYCLES);
    localparam int RC_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DC_W-1:0] DC_MAX  = '1;
    localparam bit              REP_EN  = (REPEAT_DELAY > 0);
    // Counter compare values are "cycles minus one" because the counter
    // starts at zero on the edge that fires the previous pulse.
    localparam logic [RC_W-1:0] RC_FIRST = RC_W'(REP_EN ? REPEAT_DELAY - 1 : 0);
    localparam logic [RC_W-1:0] RC_NEXT  = RC_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
    localparam logic [RC_W-1:0] RC_MAX   = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DC_W-1:0]        dc_q;
    logic [RC_W-1:0]        rc_q;
    logic                   lvl_q;
    logic                   out_q;
    logic                   armed_q;
    logic                   periodic_q;

    logic                   s;
    logic                   differ;
    logic                   flip;
    logic                   rise;
    logic                   fall;
    logic                   rise_en;
    logic                   fall_en;
    logic                   rep_hit;
    logic [RC_W-1:0]        rc_target;

    // Decode the filter state into flip/edge events and the repeat hit.
    always_comb begin
        s         = sync_q[SYNC_STAGES-1];
        differ    = (s != lvl_q);
        flip      = differ && (dc_q == DC_LAST);
        rise      = flip && !lvl_q;
        fall      = flip && lvl_q;
        rise_en   = (mode == MODE_RISE) || (mode == MODE_BOTH);
        fall_en   = (mode == MODE_FALL) || (mode == MODE_BOTH);
        rc_target = periodic_q ? RC_NEXT : RC_FIRST;
        // A flip edge always wins: no repeat on the edge where L falls.
        rep_hit   = REP_EN && armed_q && lvl_q && !flip && rise_en &&
                    (rc_q == rc_target);
    end

    // Synchronizer chain bringing the raw input into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
        end
    end

    // Debounce: count consecutive disagreeing samples, flip L on the last one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dc_q  <= '0;
            lvl_q <= 1'b0;
        end else begin
            if (!differ || flip) begin
                dc_q <= '0;
            end else if (dc_q != DC_MAX) begin
                dc_q <= dc_q + 1'b1;
            end
            if (flip) begin
                lvl_q <= !lvl_q;
            end
        end
    end

    // Auto-repeat: armed only by a rise flip seen with rise enabled, dropped
    // when L falls or rise is disabled, so re-enabling mid-hold stays quiet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed_q    <= 1'b0;
            periodic_q <= 1'b0;
            rc_q       <= '0;
        end else if (rise) begin
            armed_q    <= REP_EN && rise_en;
            periodic_q <= 1'b0;
            rc_q       <= '0;
        end else if (fall || !rise_en || !lvl_q) begin
            armed_q    <= 1'b0;
            periodic_q <= 1'b0;
            rc_q       <= '0;
        end else if (armed_q) begin
            if (rep_hit) begin
                periodic_q <= 1'b1;
                rc_q       <= '0;
            end else if (rc_q != RC_MAX) begin
                rc_q <= rc_q + 1'b1;
            end
        end
    end

    // Registered single-cycle pulse output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= 1'b0;
        end else begin
            out_q <= (rise && rise_en) || (fall && fall_en) || rep_hit;
        end
    end

    assign out   = out_q;
    assign level = lvl_q;

endmodule

// File: rtl/pulse_catcher_n.sv
// Multi-channel input conditioner: CHANNELS independent copies of the
// synchronize / debounce / edge-detect / auto-repeat channel.
module pulse_catcher_n
    import pulse_catcher_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   in,
    input  logic [2*CHANNELS-1:0] mode,
    output logic [CHANNELS-1:0]   out,
    output logic [CHANNELS-1:0]   level
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pulse_catcher_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .in    (in[i]),
            .mode  (mode[2*i +: 2]),
            .out   (out[i]),
            .level (level[i])
        );
    end

endmodule
